wb_arb2: RTL and testbench
==========================

Name:
wb_arb2

Overview:
- Two-master, one-slave Wishbone B3 arbiter.
- Shares the block RAM slave between the LM32 instruction bus (master 0) and the LM32 data bus (master 1), for configurations that bypass the full crossbar.
- Uses round-robin arbitration with a registered grant. Grant is held for the whole CYC envelope, so bursts (CTI/BTE) and locked sequences are never split.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT, 255, cycles of unanswered STB before a bus error (only with the optional feature); legal range 2..65535.

Ports:
- clk_i  in  1  system clock, all logic on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mN_adr_i  in  AW  master N address (N = 0, 1).
- mN_dat_i  in  DW  master N write data.
- mN_dat_o  out  DW  read data to master N.
- mN_sel_i  in  DW/8  byte selects.
- mN_we_i  in  1  write enable.
- mN_cyc_i  in  1  cycle request.
- mN_stb_i  in  1  strobe.
- mN_cti_i  in  3  cycle type.
- mN_bte_i  in  2  burst type.
- mN_ack_o, mN_err_o, mN_rty_o  out  1 each  responses to master N.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_sel_o  out  DW/8  slave byte selects.
- s_we_o, s_cyc_o, s_stb_o  out  1 each  slave controls.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst type.
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave responses.
- gnt_o  out  2  one-hot current grant, for debug and LEDs.

Behaviour:
- Reset state (rst_i low, asynchronous):
  - State is IDLE, gnt_o = 2'b00, last_grant = 1, so master 0 wins the first tie.
  - All s_* control outputs are 0; all mN_ack/err/rty_o are 0.
- States:
  - IDLE: no grant.
  - G0: master 0 granted.
  - G1: master 1 granted.
- IDLE transitions:
  - Only m0_cyc_i high -> G0.
  - Only m1_cyc_i high -> G1.
  - Both high -> grant the master not equal to last_grant.
  - Grant takes effect at the next edge, so arbitration latency is 1 cycle from CYC to s_cyc_o.
- GN transitions:
  - Stay in GN while mN_cyc_i = 1.
  - When mN_cyc_i falls: if the other master's CYC is high, go directly to that grant; else go to IDLE.
  - last_grant <= N on every entry to GN.
  - Handover costs 1 dead cycle; s_cyc_o is low in that cycle.
- Slave side: s_adr/dat/sel/we/cti/bte_o are a combinational mux of the granted master's signals. Master 0's signals drive the bus in IDLE.
- s_cyc_o = mN_cyc_i and s_stb_o = mN_stb_i for the granted N; both are 0 in IDLE.
- Responses: ack/err/rty are routed only to the granted master; the non-granted master sees 0. mN_dat_o = s_dat_i for both masters (broadcast).
- Responses are combinational pass-through; the arbiter adds no wait states inside a granted cycle.
- Mid-cycle CYC drop: the master abandoning a cycle releases the grant immediately on the next edge; a late slave ack is discarded.
- mN_stb_i without mN_cyc_i is ignored.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit watchdog counts cycles with s_stb_o = 1 and no ack/err/rty.
  - When the count reaches TIMEOUT, the arbiter asserts mN_err_o of the granted master for exactly 1 cycle and forces s_cyc_o/s_stb_o low in that cycle.
  - The counter clears on any response, on a grant change, and on reset.
- Without the macro: no counter exists, err is pure pass-through, and an unanswered strobe hangs indefinitely.

Test Plan:
- Reset then m0_cyc_i/stb_i high, single read, slave acks with s_dat_i = 32'hDEADBEEF -> s_cyc_o high 1 cycle after request, m0_ack_o = 1, m0_dat_o = 32'hDEADBEEF, m1_ack_o = 0.
- Both CYC rise in the same cycle from reset -> G0 first. After m0 drops CYC: 1 dead cycle, then G1. On the next simultaneous request after both idle, m0 wins (last_grant = 1 again alternates correctly).
- Master 1 performs a 4-beat incrementing burst (cti 3'b010 x3, 3'b111) while m0_cyc_i is held high -> all 4 acks go to m1, gnt_o stays 2'b10 throughout, then switches to 2'b01.
- Master 0 drops CYC before the slave acks; slave acks 1 cycle later -> no ack seen on either master, FSM returns to IDLE.
- WB_ARB_TIMEOUT_EN with TIMEOUT = 8, slave never acks -> m0_err_o pulses exactly once, 8 cycles after s_stb_o first goes high, with s_stb_o low that cycle. Without the macro, no err occurs within 1000 cycles.
- Assert rst_i low during a granted burst -> s_cyc_o, s_stb_o and all acks drop without waiting for a clock, gnt_o = 2'b00; after release, arbitration restarts with m0 priority.

Source files
------------

// File: rtl/wb_arb2.sv
// wb_arb2: two-master, one-slave Wishbone B3 round-robin arbiter with a registered grant.
// Define WB_ARB_TIMEOUT_EN to add the unanswered-strobe watchdog that answers with a bus error.
module wb_arb2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    output logic [1:0]      gnt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_arb2: TIMEOUT must lie in 2..65535");
    end

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       g0, g1;
    logic       cyc_g, stb_g;
    logic       timeout;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_q ? ST_G0 : ST_G1;
                else if (m0_cyc_i)        state_d = ST_G0;
                else if (m1_cyc_i)        state_d = ST_G1;
            end
            ST_G0:   if (!m0_cyc_i) state_d = m1_cyc_i ? ST_G1 : ST_IDLE;
            ST_G1:   if (!m1_cyc_i) state_d = m0_cyc_i ? ST_G0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_G0 && state_q != ST_G0) last_d = 1'b0;
        if (state_d == ST_G1 && state_q != ST_G1) last_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign g0    = (state_q == ST_G0);
    assign g1    = (state_q == ST_G1);
    assign gnt_o = {g1, g0};

    // A strobe only counts while its own CYC is asserted.
    assign cyc_g = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
    assign stb_g = (g0 & m0_cyc_i & m0_stb_i) | (g1 & m1_cyc_i & m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        resp;

    assign resp    = s_ack_i | s_err_i | s_rty_i;
    assign timeout = stb_g && (wd_q == 16'(TIMEOUT));

    always_comb begin
        wd_d = wd_q;
        if (resp || timeout || (state_d != state_q)) wd_d = '0;
        else if (stb_g)                               wd_d = wd_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Master 0 owns the shared bus lines whenever master 1 is not granted.
    assign s_adr_o = g1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = g1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o = g1 ? m1_sel_i : m0_sel_i;
    assign s_we_o  = g1 ? m1_we_i  : m0_we_i;
    assign s_cti_o = g1 ? m1_cti_i : m0_cti_i;
    assign s_bte_o = g1 ? m1_bte_i : m0_bte_i;
    assign s_cyc_o = cyc_g & ~timeout;
    assign s_stb_o = stb_g & ~timeout;

    // Responses reach a master only while it still holds CYC; late acks after abandon are dropped.
    assign m0_ack_o = g0 & m0_cyc_i & s_ack_i & ~timeout;
    assign m0_rty_o = g0 & m0_cyc_i & s_rty_i & ~timeout;
    assign m0_err_o = g0 & m0_cyc_i & (s_err_i | timeout);
    assign m1_ack_o = g1 & m1_cyc_i & s_ack_i & ~timeout;
    assign m1_rty_o = g1 & m1_cyc_i & s_rty_i & ~timeout;
    assign m1_err_o = g1 & m1_cyc_i & (s_err_i | timeout);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: directed table-driven bench for wb_arb2 plus hand-written multi-cycle sequences.
// With WB_ARB_TIMEOUT_EN defined the DUT is built with TIMEOUT = 8 and the watchdog is checked.
module tb_wb_arb2;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o, m0_rty_o;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o, m1_rty_o;
    logic [2:0]  m0_cti_i, m1_cti_i, s_cti_o;
    logic [1:0]  m0_bte_i, m1_bte_i, s_bte_o, gnt_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    wb_arb2 #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i),
        .m0_bte_i(m0_bte_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i),
        .m1_bte_i(m1_bte_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o),
        .s_bte_o(s_bte_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    typedef struct {
        logic       m0c, m0s, m1c, m1s, ack;
        logic [1:0] gnt;
        logic       scyc, sstb, a0, a1;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic m0c, input logic m0s, input logic m1c, input logic m1s,
                         input logic ack);
        m0_cyc_i = m0c; m0_stb_i = m0s; m1_cyc_i = m1c; m1_stb_i = m1s; s_ack_i = ack;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    initial begin
        m0_adr_i = 32'h1000_0000; m0_dat_i = 32'hA0A0_A0A0; m0_sel_i = 4'h3; m0_we_i = 1'b0;
        m1_adr_i = 32'h2000_0000; m1_dat_i = 32'hB1B1_B1B1; m1_sel_i = 4'hC; m1_we_i = 1'b1;
        m0_cti_i = 3'b000; m1_cti_i = 3'b000; m0_bte_i = 2'b00; m1_bte_i = 2'b01;
        s_dat_i  = 32'hDEAD_BEEF; s_err_i = 1'b0; s_rty_i = 1'b0;

        //            m0c m0s m1c m1s ack  gnt   scyc sstb a0 a1
        vecs[0]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0};
        vecs[4]  = '{1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0};
        vecs[5]  = '{1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1};
        vecs[6]  = '{1, 1, 0, 0, 1, 2'b10, 0, 0, 0, 0};
        vecs[7]  = '{1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 0};
        vecs[8]  = '{0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 1, 1, 0, 2'b10, 1, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 1, 0, 2'b10, 0, 0, 0, 0};
        vecs[11] = '{0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0};

        do_reset();
        #1;
        check("reset gnt", 64'(gnt_o), 64'(2'b00));
        check("reset s_cyc/stb", 64'({s_cyc_o, s_stb_o}), 64'(0));
        check("reset acks", 64'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 64'(0));

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].m0c, vecs[i].m0s, vecs[i].m1c, vecs[i].m1s, vecs[i].ack);
            #1;
            check($sformatf("v%0d gnt", i), 64'(gnt_o), 64'(vecs[i].gnt));
            check($sformatf("v%0d s_cyc", i), 64'(s_cyc_o), 64'(vecs[i].scyc));
            check($sformatf("v%0d s_stb", i), 64'(s_stb_o), 64'(vecs[i].sstb));
            check($sformatf("v%0d m0_ack", i), 64'(m0_ack_o), 64'(vecs[i].a0));
            check($sformatf("v%0d m1_ack", i), 64'(m1_ack_o), 64'(vecs[i].a1));
            check($sformatf("v%0d s_adr", i), 64'(s_adr_o),
                  (vecs[i].gnt == 2'b10) ? 64'h2000_0000 : 64'h1000_0000);
            if (i == 2) begin
                check("m0_dat broadcast", 64'(m0_dat_o), 64'hDEAD_BEEF);
                check("m1_dat broadcast", 64'(m1_dat_o), 64'hDEAD_BEEF);
            end
            tick();
        end

        // Simultaneous request straight out of reset, handover with one dead cycle.
        do_reset();
        drive(1, 1, 1, 1, 0);
        #1 check("tie idle gnt", 64'(gnt_o), 64'(2'b00));
        tick();
        check("tie -> G0", 64'(gnt_o), 64'(2'b01));
        check("tie s_cyc", 64'(s_cyc_o), 64'(1));
        drive(0, 0, 1, 1, 0);
        #1 check("dead cycle s_cyc", 64'(s_cyc_o), 64'(0));
        tick();
        check("handover -> G1", 64'(gnt_o), 64'(2'b10));
        check("handover s_adr", 64'(s_adr_o), 64'h2000_0000);
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        check("both idle", 64'(gnt_o), 64'(2'b00));
        drive(1, 1, 1, 1, 0);
        tick();
        check("second tie -> G0", 64'(gnt_o), 64'(2'b01));

        // m0 releases, m1 runs a 4-beat burst while m0 keeps requesting.
        drive(0, 0, 1, 1, 0);
        tick();
        check("burst grant", 64'(gnt_o), 64'(2'b10));
        drive(1, 1, 1, 1, 1);
        for (int b = 0; b < 4; b++) begin
            m1_cti_i = (b == 3) ? 3'b111 : 3'b010;
            #1;
            check($sformatf("burst%0d m1_ack", b), 64'(m1_ack_o), 64'(1));
            check($sformatf("burst%0d m0_ack", b), 64'(m0_ack_o), 64'(0));
            check($sformatf("burst%0d gnt", b), 64'(gnt_o), 64'(2'b10));
            check($sformatf("burst%0d cti", b), 64'(s_cti_o), (b == 3) ? 64'h7 : 64'h2);
            tick();
        end
        m1_cti_i = 3'b000;
        drive(1, 1, 0, 0, 0);
        #1 check("burst end dead", 64'(s_cyc_o), 64'(0));
        tick();
        check("after burst gnt", 64'(gnt_o), 64'(2'b01));
        check("after burst s_cyc", 64'(s_cyc_o), 64'(1));

        // m0 abandons its cycle; the slave acks one cycle late.
        drive(0, 0, 0, 0, 0);
        #1 check("abandon s_cyc", 64'(s_cyc_o), 64'(0));
        tick();
        s_ack_i = 1'b1;
        #1;
        check("late ack m0", 64'(m0_ack_o), 64'(0));
        check("late ack m1", 64'(m1_ack_o), 64'(0));
        check("abandon -> idle", 64'(gnt_o), 64'(2'b00));
        s_ack_i = 1'b0;

        // Asynchronous reset in the middle of a granted m1 cycle.
        drive(0, 0, 1, 1, 0);
        tick();
        check("pre-reset gnt", 64'(gnt_o), 64'(2'b10));
        s_ack_i = 1'b1;
        #1 rst_i = 1'b0;
        #1;
        check("async rst s_cyc/stb", 64'({s_cyc_o, s_stb_o}), 64'(0));
        check("async rst acks", 64'({m0_ack_o, m1_ack_o}), 64'(0));
        check("async rst gnt", 64'(gnt_o), 64'(2'b00));
        tick();
        rst_i = 1'b1;
        drive(1, 1, 1, 1, 0);
        tick();
        check("post-reset m0 priority", 64'(gnt_o), 64'(2'b01));

        // Unanswered strobe: watchdog error when enabled, indefinite hang otherwise.
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        drive(1, 1, 0, 0, 0);
        tick();
        begin
            int errs;
            int first;
            errs  = 0;
            first = -1;
            for (int i = 0; i < 1000; i++) begin
                #1;
                if (m0_err_o) begin
                    errs++;
                    if (first < 0) first = i;
                    check("timeout s_stb low", 64'(s_stb_o), 64'(0));
`ifdef WB_ARB_TIMEOUT_EN
                    drive(0, 0, 0, 0, 0);
`endif
                end
                tick();
            end
`ifdef WB_ARB_TIMEOUT_EN
            check("timeout err count", 64'(errs), 64'(1));
            check("timeout err cycle", 64'(first), 64'(TO));
`else
            check("no timeout err", 64'(errs), 64'(0));
            check("hang keeps s_stb", 64'(s_stb_o), 64'(1));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
